// File: rtl/ras_ckpt_stack.sv
// Return-address stack with a single pointer/top-entry checkpoint for mispredict recovery.
// Optional macro RAS_STATS_EN adds saturating overflow/underflow event counters.
module ras_ckpt_stack #(
    parameter int DEPTH = 2,
    parameter int VLEN  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [VLEN-1:0]            data_i,
    output logic                       top_valid_o,
    output logic [VLEN-1:0]            top_addr_o,
    input  logic                       ckpt_save_i,
    input  logic                       ckpt_restore_i,
`ifdef RAS_STATS_EN
    output logic [15:0]                overflow_cnt_o,
    output logic [15:0]                underflow_cnt_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [VLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   tp;
    logic [CW-1:0]   cnt;

    logic [PW-1:0]   snap_tp;
    logic [CW-1:0]   snap_cnt;
    logic [VLEN-1:0] snap_addr;

    logic [PW-1:0]   tp_nx;
    logic [CW-1:0]   cnt_nx;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;
    logic [VLEN-1:0] wr_data;
    logic [VLEN-1:0] save_addr;
    logic            push_only;
    logic            pop_only;
    logic            ops_live;

    // Pointer arithmetic wraps explicitly so non-power-of-two depths stay in range.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? LAST_PTR : p - 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign ops_live  = !flush_i && !ckpt_restore_i;
    assign push_only = push_i && !pop_i;
    assign pop_only  = pop_i && !push_i;

    always_comb begin
        tp_nx   = tp;
        cnt_nx  = cnt;
        wr_en   = 1'b0;
        wr_idx  = tp;
        wr_data = data_i;
        if (flush_i) begin
            cnt_nx = '0;
        end else if (ckpt_restore_i) begin
            tp_nx   = snap_tp;
            cnt_nx  = snap_cnt;
            wr_en   = 1'b1;
            wr_idx  = snap_tp;
            wr_data = snap_addr;
        end else if (push_i && pop_i) begin
            // Return-and-call: replace the top entry in place.
            wr_en = 1'b1;
            if (cnt == '0) begin
                cnt_nx = CW'(1);
            end
        end else if (push_i) begin
            tp_nx  = ptr_inc(tp);
            wr_en  = 1'b1;
            wr_idx = ptr_inc(tp);
            cnt_nx = (cnt == FULL_CNT) ? FULL_CNT : cnt + 1'b1;
        end else if (pop_i && cnt != '0) begin
            tp_nx  = ptr_dec(tp);
            cnt_nx = cnt - 1'b1;
        end
    end

    // The snapshot sees this cycle's write, so forward it ahead of the array read.
    assign save_addr = (wr_en && wr_idx == tp_nx) ? wr_data : mem[tp_nx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            tp        <= '0;
            cnt       <= '0;
            snap_tp   <= '0;
            snap_cnt  <= '0;
            snap_addr <= '0;
        end else begin
            tp  <= tp_nx;
            cnt <= cnt_nx;
            if (wr_en) begin
                mem[wr_idx] <= wr_data;
            end
            if (ckpt_save_i) begin
                snap_tp   <= tp_nx;
                snap_cnt  <= cnt_nx;
                snap_addr <= save_addr;
            end
        end
    end

`ifdef RAS_STATS_EN
    logic [15:0] ovf_cnt;
    logic [15:0] unf_cnt;

    // Only operations that actually reach the stack are counted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else begin
            if (ops_live && push_only && cnt == FULL_CNT) begin
                ovf_cnt <= sat_inc16(ovf_cnt);
            end
            if (ops_live && pop_only && cnt == '0) begin
                unf_cnt <= sat_inc16(unf_cnt);
            end
        end
    end

    assign overflow_cnt_o  = ovf_cnt;
    assign underflow_cnt_o = unf_cnt;
`else
    logic unused_stats;
    assign unused_stats = ops_live ^ push_only ^ pop_only;
`endif

    assign top_addr_o  = mem[tp];
    assign top_valid_o = (cnt != '0);
    assign count_o     = cnt;

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Directed bench for ras_ckpt_stack (DEPTH=2, VLEN=32) with hand-computed expectations.
module tb_ras_ckpt_stack;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i, push_i, pop_i, ckpt_save_i, ckpt_restore_i;
    logic [31:0] data_i;
    logic        top_valid_o;
    logic [31:0] top_addr_o;
    logic [1:0]  count_o;
`ifdef RAS_STATS_EN
    logic [15:0] overflow_cnt_o, underflow_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    ras_ckpt_stack #(.DEPTH(2), .VLEN(32)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .push_i         (push_i),
        .pop_i          (pop_i),
        .data_i         (data_i),
        .top_valid_o    (top_valid_o),
        .top_addr_o     (top_addr_o),
        .ckpt_save_i    (ckpt_save_i),
        .ckpt_restore_i (ckpt_restore_i),
`ifdef RAS_STATS_EN
        .overflow_cnt_o (overflow_cnt_o),
        .underflow_cnt_o(underflow_cnt_o),
`endif
        .count_o        (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of controls, clock it, and return 1ns after the edge.
    task automatic cyc(input logic psh, input logic pp, input logic [31:0] d,
                       input logic sv, input logic rs, input logic fl);
        push_i = psh; pop_i = pp; data_i = d;
        ckpt_save_i = sv; ckpt_restore_i = rs; flush_i = fl;
        @(posedge clk_i);
        #1;
        push_i = 0; pop_i = 0; data_i = '0;
        ckpt_save_i = 0; ckpt_restore_i = 0; flush_i = 0;
    endtask

    task automatic expect_state(input string tag, input logic v, input logic [31:0] a, input logic [1:0] c);
        check({tag, ".valid"}, 32'(top_valid_o), 32'(v));
        check({tag, ".addr"},  top_addr_o, a);
        check({tag, ".count"}, 32'(count_o), 32'(c));
    endtask

    initial begin
        rst_ni = 0;
        push_i = 0; pop_i = 0; data_i = '0;
        ckpt_save_i = 0; ckpt_restore_i = 0; flush_i = 0;
        #12;
        expect_state("reset", 0, 32'h0, 2'd0);
`ifdef RAS_STATS_EN
        check("reset.ovf", 32'(overflow_cnt_o), 32'd0);
        check("reset.unf", 32'(underflow_cnt_o), 32'd0);
`endif
        rst_ni = 1;

        // Basic push/pop
        cyc(1, 0, 32'h100, 0, 0, 0);
        cyc(1, 0, 32'h200, 0, 0, 0);
        expect_state("push2", 1, 32'h200, 2'd2);
        cyc(0, 1, 32'h0, 0, 0, 0);
        expect_state("pop1", 1, 32'h100, 2'd1);
        cyc(0, 1, 32'h0, 0, 0, 0);
        check("pop2.valid", 32'(top_valid_o), 32'd0);
        check("pop2.count", 32'(count_o), 32'd0);

        // Overflow wraps over the oldest entry
        cyc(1, 0, 32'h10, 0, 0, 0);
        cyc(1, 0, 32'h20, 0, 0, 0);
        cyc(1, 0, 32'h30, 0, 0, 0);
        expect_state("ovf.push3", 1, 32'h30, 2'd2);
        cyc(0, 1, 32'h0, 0, 0, 0);
        expect_state("ovf.pop1", 1, 32'h20, 2'd1);
        cyc(0, 1, 32'h0, 0, 0, 0);
        check("ovf.pop2.valid", 32'(top_valid_o), 32'd0);
`ifdef RAS_STATS_EN
        check("ovf.cnt", 32'(overflow_cnt_o), 32'd1);
`endif

        // Underflow: pointer must not move, top address stays at mem[tp]=0x30
        cyc(0, 1, 32'h0, 0, 0, 0);
        cyc(0, 1, 32'h0, 0, 0, 0);
        expect_state("unf", 0, 32'h30, 2'd0);
`ifdef RAS_STATS_EN
        check("unf.cnt", 32'(underflow_cnt_o), 32'd2);
`endif

        // Simultaneous push and pop replaces top
        cyc(1, 0, 32'h100, 0, 0, 0);
        cyc(1, 0, 32'h200, 0, 0, 0);
        cyc(1, 1, 32'h300, 0, 0, 0);
        expect_state("pushpop", 1, 32'h300, 2'd2);
        cyc(0, 1, 32'h0, 0, 0, 0);
        expect_state("pushpop.pop", 1, 32'h100, 2'd1);
        cyc(0, 1, 32'h0, 0, 0, 0);
        check("drain.count", 32'(count_o), 32'd0);

        // Checkpoint save then restore after further pushes
        cyc(1, 0, 32'h100, 0, 0, 0);
        cyc(0, 0, 32'h0, 1, 0, 0);
        cyc(1, 0, 32'h200, 0, 0, 0);
        cyc(1, 0, 32'h300, 0, 0, 0);
        expect_state("ckpt.pre", 1, 32'h300, 2'd2);
        cyc(0, 0, 32'h0, 0, 1, 0);
        expect_state("ckpt.restore", 1, 32'h100, 2'd1);
        cyc(1, 0, 32'h500, 0, 1, 0);
        expect_state("ckpt.restore_push", 1, 32'h100, 2'd1);

        // Save in the same cycle as a push captures the post-push state
        cyc(1, 0, 32'h600, 1, 0, 0);
        cyc(1, 0, 32'h700, 0, 0, 0);
        cyc(1, 0, 32'h800, 0, 0, 0);
        cyc(0, 0, 32'h0, 0, 1, 0);
        expect_state("ckpt.same_cycle", 1, 32'h600, 2'd2);

        // Flush beats restore and push; a save alongside captures count 0
        cyc(1, 0, 32'h900, 1, 1, 1);
        check("flush.valid", 32'(top_valid_o), 32'd0);
        check("flush.count", 32'(count_o), 32'd0);
        cyc(0, 0, 32'h0, 0, 1, 0);
        check("flush.snap_count", 32'(count_o), 32'd0);

        // Push+pop on empty writes in place and yields one entry
        cyc(1, 1, 32'hAAA, 0, 0, 0);
        expect_state("pushpop.empty", 1, 32'hAAA, 2'd1);

        // Asynchronous reset in the middle of a push, checked before any clock edge
        push_i = 1; data_i = 32'hBBB;
        #2 rst_ni = 0;
        #1;
        expect_state("async_rst", 0, 32'h0, 2'd0);
`ifdef RAS_STATS_EN
        check("async_rst.ovf", 32'(overflow_cnt_o), 32'd0);
        check("async_rst.unf", 32'(underflow_cnt_o), 32'd0);
`endif
        push_i = 0; data_i = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
